// File: rtl/n0_tile_sequencer.sv
// n0_tile_sequencer: issues NBin/SB reads for one layer tile, delay-matches control
// to the fixed-latency n0 datapath and drives NBout writeback.
module n0_tile_sequencer #(
   parameter int ADDR_W   = 10,
   parameter int CNT_W    = 8,
   parameter int PIPE_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_num_in_blk,
   input  logic [CNT_W-1:0]  i_num_out_blk,
   input  logic [ADDR_W-1:0] i_nbin_base,
   input  logic [ADDR_W-1:0] i_sb_base,
   input  logic              i_stall,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_nbin_addr,
   output logic [ADDR_W-1:0] o_sb_addr,
   output logic              o_psum_sel,
   output logic              o_nbout_wr_en,
   output logic [ADDR_W-1:0] o_nbout_addr,
   output logic              o_last_wb
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   typedef struct packed {
      logic             v;
      logic [CNT_W-1:0] ob;
      logic             ps;
      logic             last;
   } stage_t;
   state_t            state;
   stage_t            dl [PIPE_LAT];
   logic [CNT_W-1:0]  nib, nob, ib, ob;
   logic [ADDR_W-1:0] nbin_a, sb_a;
   logic              issue, last_ob, last_ib, pending;
   assign issue   = state == ISSUE && !i_stall;
   assign last_ob = ob == nob - CNT_W'(1);
   assign last_ib = ib == nib - CNT_W'(1);
   // entries still ahead of the output stage; the output stage itself retires this cycle
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < PIPE_LAT - 1; i++) pending = pending | dl[i].v;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         nib    <= '0;
         nob    <= '0;
         ib     <= '0;
         ob     <= '0;
         nbin_a <= '0;
         sb_a   <= '0;
         for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
      end else begin
         dl[0] <= issue ? {1'b1, ob, ib != '0, last_ib} : '0;
         for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
         case (state)
            IDLE: if (i_start) begin
               nib    <= i_num_in_blk;
               nob    <= i_num_out_blk;
               ib     <= '0;
               ob     <= '0;
               nbin_a <= i_nbin_base;
               sb_a   <= i_sb_base;
               state  <= (i_num_in_blk == '0 || i_num_out_blk == '0) ? DONE : ISSUE;
            end
            // sb address walks ib*num_out_blk+ob linearly, so a plain increment suffices
            ISSUE: if (!i_stall) begin
               sb_a <= sb_a + ADDR_W'(1);
               if (last_ob) begin
                  ob     <= '0;
                  ib     <= ib + CNT_W'(1);
                  nbin_a <= nbin_a + ADDR_W'(1);
                  if (last_ib) state <= DRAIN;
               end else begin
                  ob <= ob + CNT_W'(1);
               end
            end
            DRAIN: if (!pending) state <= DONE;
            DONE:  state <= IDLE;
         endcase
      end
   end
   assign o_busy        = state != IDLE || i_start;
   assign o_done        = state == DONE;
   assign o_rd_en       = issue;
   assign o_nbin_addr   = nbin_a;
   assign o_sb_addr     = sb_a;
   assign o_nbout_wr_en = dl[PIPE_LAT-1].v;
   assign o_nbout_addr  = ADDR_W'(dl[PIPE_LAT-1].ob);
   assign o_psum_sel    = dl[PIPE_LAT-1].ps;
   assign o_last_wb     = dl[PIPE_LAT-1].last;
endmodule
